ysyx_24110006_mem_arbiter: RTL and testbench
============================================

# ysyx_24110006_mem_arbiter

Two-master, one-slave memory arbiter between the instruction fetch path (IFU, driven by the PC stage's valid/pc) and the load/store unit (LSU), in front of the single memory port of the multi-cycle core. It accepts one transaction at a time, grants round-robin on contention, and forwards the request payload to memory. It routes the response back to the owner only, and converts a memory response that never arrives into an error response after a bounded wait.

## Interface
Parameters:
- TIMEOUT, 255, max cycles spent in WAIT before a forced error response (≥2).

Ports (one clock; reset is synchronous and active-high):
- i_clock  in  1  core clock; all state updates on posedge.
- i_reset  in  1  synchronous, active-high reset.
- i_ifu_req  in  1  IFU read request; held with address until grant.
- i_ifu_addr  in  32  IFU read address.
- o_ifu_gnt  out  1  one-cycle pulse: IFU request accepted.
- o_ifu_rvalid  out  1  one-cycle pulse: IFU response valid.
- o_ifu_rdata  out  32  IFU read data (valid with o_ifu_rvalid).
- o_ifu_err  out  1  response is a timeout error (qualified by rvalid).
- i_lsu_req  in  1  LSU request; held with payload until grant.
- i_lsu_wen  in  1  1 = write, 0 = read.
- i_lsu_addr  in  32  LSU address.
- i_lsu_wdata  in  32  write data.
- i_lsu_wmask  in  4  byte write mask.
- o_lsu_gnt, o_lsu_rvalid, o_lsu_rdata[31:0], o_lsu_err  out  LSU counterparts of the IFU outputs (a write also completes with rvalid).
- o_mem_req  out  1  request valid to memory.
- o_mem_wen, o_mem_addr[31:0], o_mem_wdata[31:0], o_mem_wmask[3:0]  out  latched payload.
- i_mem_ready  in  1  memory accepts request this cycle.
- i_mem_rvalid  in  1  memory response valid.
- i_mem_rdata  in  32  memory read data.
- o_busy  out  1  state ≠ IDLE.

## Operation
- States: IDLE, ADDR, WAIT. Owner register: IFU/LSU. Last-served register: IFU/LSU.
- IDLE:
  - If exactly one requester, it wins.
  - If both, the one ≠ last-served wins.
  - The winner's gnt is pulsed combinationally in this cycle. Payload and owner are latched, last-served is updated, and the state moves to ADDR.
  - IFU payload is forced to wen=0, wdata=0, wmask=0.
- ADDR: o_mem_req=1 with the latched payload. On i_mem_ready, go to WAIT and clear the timeout counter. Otherwise hold.
- WAIT:
  - On i_mem_rvalid, the owner's rvalid=1 and rdata=i_mem_rdata (combinational pass-through), err=0, and the state moves to IDLE.
  - Otherwise the counter increments. When the counter reaches TIMEOUT−1 without rvalid, the owner's rvalid=1, err=1, rdata=0, and the state moves to IDLE.
- The non-owner's rvalid is always 0. rdata outputs are 0 when rvalid is 0.
- Requests arriving in ADDR/WAIT get no grant and must be held. i_mem_rvalid outside WAIT is ignored.
- A late rvalid after a timeout is ignored if it arrives in IDLE. If it arrives in the next WAIT, it is accepted as that transaction's response. This is a documented limitation.
- Counter width: clog2(TIMEOUT+1); it saturates and never wraps.

## Timing
- Reset:
  - state=IDLE; last-served=LSU, so the IFU wins the first tie.
  - counter=0.
  - All outputs 0, including o_mem_* payload, gnt, rvalid, err and o_busy.
- Reset mid-transaction drops it: no rvalid/gnt is emitted, and the next cycle is IDLE.
- Minimum transaction (zero-wait memory):
  - cycle N: req seen, gnt.
  - cycle N+1: o_mem_req, ready.
  - cycle N+2: rvalid response.
  - cycle N+3: IDLE, so the next grant is possible.
- Requester→response latency is therefore 2 cycles plus memory stalls. Throughput is 1 transaction per 3 cycles at best.
- The gnt and rvalid pulses last exactly one cycle each per transaction.

## Structure
- Shared package (ysyx_24110006_pkg): state enum {IDLE, ADDR, WAIT}; owner encoding (IFU=0, LSU=1); reset PC constant 32'h80000000 (the test plan uses it).
- Sub-module ysyx_24110006_rr_arb2: two requests and a last-served bit in, one-hot grant out, combinational. The FSM, payload registers and timeout counter stay in the top.

## Test plan
- Reset, then hold IFU req with addr 0x80000000; memory ready immediately, rvalid next cycle with 0x00000413 -> o_ifu_gnt at cycle 0, o_mem_req/addr 0x80000000 at cycle 1, o_ifu_rvalid with rdata 0x00000413 at cycle 2, o_lsu_rvalid stays 0.
- IFU and LSU request together in IDLE for 4 back-to-back transactions -> grants in order IFU, LSU, IFU, LSU.
- LSU write to addr 0x80001000, wdata 0xDEADBEEF, wmask 0xF; memory holds ready low for 3 cycles -> o_mem_req and payload stable for all 4 ADDR cycles, o_lsu_rvalid=1 with err=0, no IFU gnt while busy.
- TIMEOUT=8, memory never asserts rvalid -> the owner's rvalid=1 with err=1 and rdata=0 on the 8th WAIT cycle, then IDLE, o_busy=0.
- Assert i_reset during WAIT -> next cycle state IDLE, all outputs 0, no rvalid; a subsequent IFU request wins and completes normally.
- i_mem_rvalid pulsed while in IDLE or ADDR -> no owner rvalid and no state change.

Source files
------------

// File: rtl/ysyx_24110006_pkg.sv
// Shared types for the IFU/LSU memory arbiter.
// State, owner encodings and the latched request payload.
package ysyx_24110006_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_WAIT = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  typedef struct packed {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } mem_req_t;

endpackage

// File: rtl/ysyx_24110006_rr_arb2.sv
// Two-way round-robin arbiter, combinational.
// gnt_o[0] = IFU, gnt_o[1] = LSU; ties go to the side not served last.
module ysyx_24110006_rr_arb2
  import ysyx_24110006_pkg::*;
(
  input  logic       req_ifu_i,
  input  logic       req_lsu_i,
  input  owner_e     last_i,
  output logic [1:0] gnt_o
);

  assign gnt_o[0] = req_ifu_i &&
                    (!req_lsu_i || last_i == OWN_LSU);
  assign gnt_o[1] = req_lsu_i &&
                    (!req_ifu_i || last_i == OWN_IFU);

endmodule

// File: rtl/ysyx_24110006_mem_arbiter.sv
// IFU/LSU to single memory port arbiter.
// One transaction in flight, round-robin grant, bounded response wait.
module ysyx_24110006_mem_arbiter
  import ysyx_24110006_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_ifu_req,
  input  logic [31:0] i_ifu_addr,
  output logic        o_ifu_gnt,
  output logic        o_ifu_rvalid,
  output logic [31:0] o_ifu_rdata,
  output logic        o_ifu_err,
  input  logic        i_lsu_req,
  input  logic        i_lsu_wen,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_lsu_wdata,
  input  logic [3:0]  i_lsu_wmask,
  output logic        o_lsu_gnt,
  output logic        o_lsu_rvalid,
  output logic [31:0] o_lsu_rdata,
  output logic        o_lsu_err,
  output logic        o_mem_req,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_wmask,
  input  logic        i_mem_ready,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  output logic        o_busy
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  arb_state_e    state_q, state_d;
  owner_e        owner_q, owner_d;
  owner_e        last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  mem_req_t      pay_q, pay_d;

  logic [1:0]  gnt;
  logic        ifu_gnt, lsu_gnt;
  logic        rsp_vld, rsp_err;
  logic [31:0] rsp_data;

  ysyx_24110006_rr_arb2 u_rr (
    .req_ifu_i (i_ifu_req),
    .req_lsu_i (i_lsu_req),
    .last_i    (last_q),
    .gnt_o     (gnt)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      owner_q <= OWN_IFU;
      last_q  <= OWN_LSU;
      cnt_q   <= '0;
      pay_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      pay_q   <= pay_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    pay_d    = pay_q;
    ifu_gnt  = 1'b0;
    lsu_gnt  = 1'b0;
    rsp_vld  = 1'b0;
    rsp_err  = 1'b0;
    rsp_data = '0;
    unique case (state_q)
      S_IDLE: begin
        if (gnt[0]) begin
          ifu_gnt = 1'b1;
          owner_d = OWN_IFU;
          last_d  = OWN_IFU;
          state_d = S_ADDR;
          pay_d   = '{wen: 1'b0, addr: i_ifu_addr,
                      wdata: '0, wmask: '0};
        end else if (gnt[1]) begin
          lsu_gnt = 1'b1;
          owner_d = OWN_LSU;
          last_d  = OWN_LSU;
          state_d = S_ADDR;
          pay_d   = '{wen: i_lsu_wen, addr: i_lsu_addr,
                      wdata: i_lsu_wdata, wmask: i_lsu_wmask};
        end
      end
      S_ADDR: begin
        if (i_mem_ready) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (i_mem_rvalid) begin
          rsp_vld  = 1'b1;
          rsp_data = i_mem_rdata;
          state_d  = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          rsp_vld = 1'b1;
          rsp_err = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A reset cycle drops the transaction without any pulse.
  assign o_ifu_gnt    = ifu_gnt && !i_reset;
  assign o_lsu_gnt    = lsu_gnt && !i_reset;
  assign o_ifu_rvalid = rsp_vld && owner_q == OWN_IFU && !i_reset;
  assign o_lsu_rvalid = rsp_vld && owner_q == OWN_LSU && !i_reset;
  assign o_ifu_rdata  = o_ifu_rvalid ? rsp_data : '0;
  assign o_lsu_rdata  = o_lsu_rvalid ? rsp_data : '0;
  assign o_ifu_err    = o_ifu_rvalid && rsp_err;
  assign o_lsu_err    = o_lsu_rvalid && rsp_err;

  assign o_mem_req   = state_q == S_ADDR;
  assign o_mem_wen   = pay_q.wen;
  assign o_mem_addr  = pay_q.addr;
  assign o_mem_wdata = pay_q.wdata;
  assign o_mem_wmask = pay_q.wmask;
  assign o_busy      = state_q != S_IDLE;

endmodule

// File: tb/tb_ysyx_24110006_mem_arbiter.sv
// Directed cycle-table bench for the memory arbiter (TIMEOUT=8).
// Each row drives one cycle and checks all outputs before the edge.
module tb_ysyx_24110006_mem_arbiter;
  import ysyx_24110006_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifr;
  logic [31:0] ifa;
  logic        lr, lw;
  logic [31:0] la, lwd;
  logic [3:0]  lwm;
  logic        mr, mv;
  logic [31:0] md;

  logic        ifu_gnt, ifu_rv, ifu_err;
  logic [31:0] ifu_rd;
  logic        lsu_gnt, lsu_rv, lsu_err;
  logic [31:0] lsu_rd;
  logic        mem_req, mem_wen;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        busy;

  always #5 clk = ~clk;

  ysyx_24110006_mem_arbiter #(.TIMEOUT(8)) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_ifu_req    (ifr),
    .i_ifu_addr   (ifa),
    .o_ifu_gnt    (ifu_gnt),
    .o_ifu_rvalid (ifu_rv),
    .o_ifu_rdata  (ifu_rd),
    .o_ifu_err    (ifu_err),
    .i_lsu_req    (lr),
    .i_lsu_wen    (lw),
    .i_lsu_addr   (la),
    .i_lsu_wdata  (lwd),
    .i_lsu_wmask  (lwm),
    .o_lsu_gnt    (lsu_gnt),
    .o_lsu_rvalid (lsu_rv),
    .o_lsu_rdata  (lsu_rd),
    .o_lsu_err    (lsu_err),
    .o_mem_req    (mem_req),
    .o_mem_wen    (mem_wen),
    .o_mem_addr   (mem_addr),
    .o_mem_wdata  (mem_wdata),
    .o_mem_wmask  (mem_wmask),
    .i_mem_ready  (mr),
    .i_mem_rvalid (mv),
    .i_mem_rdata  (md),
    .o_busy       (busy)
  );

  typedef struct {
    string       name;
    logic        rst, ifr;
    logic [31:0] ifa;
    logic        lr, lw;
    logic [31:0] la, lwd;
    logic [3:0]  lwm;
    logic        mr, mv;
    logic [31:0] md;
    logic [8:0]  ef;
    logic [31:0] eird, elrd, ema, ewd;
    logic [3:0]  ewm;
  } vec_t;

  vec_t tbl[$];
  int   passed = 0;
  int   total  = 0;

  localparam logic [31:0] A  = RESET_PC;
  localparam logic [31:0] B  = 32'h8000_0004;
  localparam logic [31:0] C  = 32'h8000_0008;
  localparam logic [31:0] L  = 32'h8000_2000;
  localparam logic [31:0] W  = 32'h8000_1000;
  localparam logic [31:0] L2 = 32'h8000_3000;
  localparam logic [31:0] DB = 32'hDEAD_BEEF;
  localparam logic [31:0] BD = 32'hBAD0_BAD0;

  function automatic vec_t v(
    string n, logic r, logic fi, logic [31:0] fa,
    logic sr, logic sw, logic [31:0] sa,
    logic [31:0] sd, logic [3:0] sm,
    logic y, logic rv, logic [31:0] d,
    logic [8:0] f, logic [31:0] a1, logic [31:0] a2,
    logic [31:0] a3, logic [31:0] a4, logic [3:0] a5);
    vec_t t;
    t.name = n; t.rst = r; t.ifr = fi; t.ifa = fa;
    t.lr = sr; t.lw = sw; t.la = sa; t.lwd = sd;
    t.lwm = sm; t.mr = y; t.mv = rv; t.md = d;
    t.ef = f; t.eird = a1; t.elrd = a2; t.ema = a3;
    t.ewd = a4; t.ewm = a5;
    return t;
  endfunction

  task automatic chk(string n, logic [31:0] got,
                     logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h want %h", n, got, exp);
  endtask

  task automatic idle_in();
    rst = 0; ifr = 0; ifa = 0; lr = 0; lw = 0;
    la = 0; lwd = 0; lwm = 0; mr = 0; mv = 0; md = 0;
  endtask

  initial begin
    logic [140:0] got, exp;
    int n;
    // flags: ifu_gnt ifu_rv ifu_err lsu_gnt lsu_rv
    //        lsu_err mem_req busy mem_wen
    tbl.push_back(v("reset",1,0,0,0,0,0,0,0,0,0,0,
      9'b000000000,0,0,0,0,0));
    tbl.push_back(v("ifu_gnt",0,1,A,0,0,0,0,0,0,0,0,
      9'b100000000,0,0,0,0,0));
    tbl.push_back(v("ifu_addr",0,0,0,0,0,0,0,0,1,0,0,
      9'b000000110,0,0,A,0,0));
    tbl.push_back(v("ifu_rsp",0,0,0,0,0,0,0,0,0,1,32'h413,
      9'b010000010,32'h413,0,A,0,0));
    tbl.push_back(v("ifu_idle",0,0,0,0,0,0,0,0,0,0,0,
      9'b000000000,0,0,A,0,0));
    tbl.push_back(v("reset2",1,0,0,0,0,0,0,0,0,0,0,
      9'b000000000,0,0,A,0,0));
    tbl.push_back(v("rr1_gnt",0,1,B,1,0,L,0,0,0,0,0,
      9'b100000000,0,0,0,0,0));
    tbl.push_back(v("rr1_addr",0,1,B,1,0,L,0,0,1,0,0,
      9'b000000110,0,0,B,0,0));
    tbl.push_back(v("rr1_rsp",0,1,B,1,0,L,0,0,0,1,32'h11110001,
      9'b010000010,32'h11110001,0,B,0,0));
    tbl.push_back(v("rr2_gnt",0,1,B,1,0,L,0,0,0,0,0,
      9'b000100000,0,0,B,0,0));
    tbl.push_back(v("rr2_addr",0,1,B,1,0,L,0,0,1,0,0,
      9'b000000110,0,0,L,0,0));
    tbl.push_back(v("rr2_rsp",0,1,B,1,0,L,0,0,0,1,32'h22220002,
      9'b000010010,0,32'h22220002,L,0,0));
    tbl.push_back(v("rr3_gnt",0,1,B,1,0,L,0,0,0,0,0,
      9'b100000000,0,0,L,0,0));
    tbl.push_back(v("rr3_addr",0,1,B,1,0,L,0,0,1,0,0,
      9'b000000110,0,0,B,0,0));
    tbl.push_back(v("rr3_rsp",0,1,B,1,0,L,0,0,0,1,32'h33330003,
      9'b010000010,32'h33330003,0,B,0,0));
    tbl.push_back(v("rr4_gnt",0,1,B,1,0,L,0,0,0,0,0,
      9'b000100000,0,0,B,0,0));
    tbl.push_back(v("rr4_addr",0,1,B,1,0,L,0,0,1,0,0,
      9'b000000110,0,0,L,0,0));
    tbl.push_back(v("rr4_rsp",0,1,B,1,0,L,0,0,0,1,32'h44440004,
      9'b000010010,0,32'h44440004,L,0,0));
    tbl.push_back(v("wr_gnt",0,0,0,1,1,W,DB,4'hF,0,0,0,
      9'b000100000,0,0,L,0,0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(v("wr_stall",0,1,B,0,0,0,0,0,0,0,0,
        9'b000000111,0,0,W,DB,4'hF));
    tbl.push_back(v("wr_accept",0,1,B,0,0,0,0,0,1,0,0,
      9'b000000111,0,0,W,DB,4'hF));
    tbl.push_back(v("wr_rsp",0,1,B,0,0,0,0,0,0,1,0,
      9'b000010011,0,0,W,DB,4'hF));
    tbl.push_back(v("to_gnt",0,1,C,0,0,0,0,0,0,0,0,
      9'b100000001,0,0,W,DB,4'hF));
    tbl.push_back(v("to_addr",0,0,0,0,0,0,0,0,1,0,0,
      9'b000000110,0,0,C,0,0));
    for (int i = 0; i < 7; i++)
      tbl.push_back(v("to_wait",0,0,0,0,0,0,0,0,0,0,BD,
        9'b000000010,0,0,C,0,0));
    tbl.push_back(v("to_err",0,0,0,0,0,0,0,0,0,0,BD,
      9'b011000010,0,0,C,0,0));
    tbl.push_back(v("to_idle",0,0,0,0,0,0,0,0,0,0,0,
      9'b000000000,0,0,C,0,0));
    tbl.push_back(v("rw_gnt",0,1,A,0,0,0,0,0,0,0,0,
      9'b100000000,0,0,C,0,0));
    tbl.push_back(v("rw_addr",0,0,0,0,0,0,0,0,1,0,0,
      9'b000000110,0,0,A,0,0));
    tbl.push_back(v("rw_rst",1,0,0,0,0,0,0,0,0,1,32'h55,
      9'b000000010,0,0,A,0,0));
    tbl.push_back(v("rw_post",0,0,0,0,0,0,0,0,0,0,0,
      9'b000000000,0,0,0,0,0));
    tbl.push_back(v("rw2_gnt",0,1,B,0,0,0,0,0,0,0,0,
      9'b100000000,0,0,0,0,0));
    tbl.push_back(v("rw2_addr",0,0,0,0,0,0,0,0,1,0,0,
      9'b000000110,0,0,B,0,0));
    tbl.push_back(v("rw2_rsp",0,0,0,0,0,0,0,0,0,1,32'h66,
      9'b010000010,32'h66,0,B,0,0));
    tbl.push_back(v("rv_idle",0,0,0,0,0,0,0,0,0,1,32'h77,
      9'b000000000,0,0,B,0,0));
    tbl.push_back(v("rv_gnt",0,0,0,1,0,L,0,0,0,1,32'h77,
      9'b000100000,0,0,B,0,0));
    tbl.push_back(v("rv_addr",0,0,0,0,0,0,0,0,0,1,32'h77,
      9'b000000110,0,0,L,0,0));
    tbl.push_back(v("rv_addr_rdy",0,0,0,0,0,0,0,0,1,1,32'h77,
      9'b000000110,0,0,L,0,0));
    tbl.push_back(v("rv_rsp",0,0,0,0,0,0,0,0,0,1,32'h88,
      9'b000010010,0,32'h88,L,0,0));
    tbl.push_back(v("rv_done",0,0,0,0,0,0,0,0,0,0,0,
      9'b000000000,0,0,L,0,0));

    idle_in();
    rst = 1;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      rst = tbl[i].rst; ifr = tbl[i].ifr; ifa = tbl[i].ifa;
      lr = tbl[i].lr; lw = tbl[i].lw; la = tbl[i].la;
      lwd = tbl[i].lwd; lwm = tbl[i].lwm;
      mr = tbl[i].mr; mv = tbl[i].mv; md = tbl[i].md;
      @(negedge clk);
      got = {ifu_gnt, ifu_rv, ifu_err, lsu_gnt, lsu_rv,
             lsu_err, mem_req, busy, mem_wen, ifu_rd,
             lsu_rd, mem_addr, mem_wdata, mem_wmask};
      exp = {tbl[i].ef, tbl[i].eird, tbl[i].elrd,
             tbl[i].ema, tbl[i].ewd, tbl[i].ewm};
      total++;
      if (got === exp) passed++;
      else $display("FAIL row%0d %s: got %h want %h",
                    i, tbl[i].name, got, exp);
      @(posedge clk); #1;
    end

    // LSU-owned timeout: count WAIT cycles until the error.
    idle_in();
    lr = 1; la = L2;
    @(negedge clk);
    chk("lsu_to_gnt", 32'(lsu_gnt), 32'd1);
    @(posedge clk); #1;
    lr = 0; mr = 1;
    @(negedge clk);
    chk("lsu_to_addr", mem_addr, L2);
    @(posedge clk); #1;
    mr = 0; md = BD;
    n = 41;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (lsu_rv) begin
        n = k;
        break;
      end
      @(posedge clk); #1;
    end
    chk("lsu_to_cycles", n, 8);
    chk("lsu_to_err", 32'(lsu_err), 32'd1);
    chk("lsu_to_rdata", lsu_rd, 32'd0);
    chk("lsu_to_ifu_rv", 32'(ifu_rv), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lsu_to_busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
